// File: rtl/papu_mixer.sv
// Nonlinear NES-style APU channel mixer: pulse/TND lookup mix, channel mute,
// power-of-two box-filter decimation, attenuation and optional signed output.
module papu_mixer #(
    parameter int OUT_W      = 16,
    parameter int DECIM_LOG2 = 0,
    parameter int SIGNED_OUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [3:0]       sq1,
    input  logic [3:0]       sq2,
    input  logic [3:0]       triangle,
    input  logic [3:0]       noise,
    input  logic [6:0]       dmc,
    input  logic [4:0]       ch_enable,
    input  logic [1:0]       vol,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid
);

    // Strobe protocol: tick is a qualifier with no backpressure; codes and
    // ch_enable are taken on any tick cycle, and sample_valid marks the single
    // cycle in which sample_out takes a new value.

    localparam longint FULL  = (longint'(1) << OUT_W) - 1;
    localparam int     CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int     ACC_W = OUT_W + DECIM_LOG2;
    localparam logic [OUT_W-1:0] HALF = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] RESET_OUT = (SIGNED_OUT != 0) ? HALF : '0;

    typedef logic [OUT_W-1:0] sq_tbl_t  [0:30];
    typedef logic [OUT_W-1:0] tnd_tbl_t [0:202];

    // Exact rational rounding: 95.52/(8128/n+100) == 9552*n / (100*(8128+100*n)).
    function automatic sq_tbl_t build_sq_tbl();
        sq_tbl_t t;
        longint  num;
        longint  den;
        for (int n = 0; n < 31; n++) begin
            if (n == 0) begin
                t[n] = '0;
            end else begin
                num  = 64'd9552 * longint'(n) * FULL;
                den  = 64'd100 * (64'd8128 + 64'd100 * longint'(n));
                t[n] = OUT_W'((2 * num + den) / (2 * den));
            end
        end
        return t;
    endfunction

    function automatic tnd_tbl_t build_tnd_tbl();
        tnd_tbl_t t;
        longint   num;
        longint   den;
        for (int n = 0; n < 203; n++) begin
            if (n == 0) begin
                t[n] = '0;
            end else begin
                num  = 64'd16367 * longint'(n) * FULL;
                den  = 64'd100 * (64'd24329 + 64'd100 * longint'(n));
                t[n] = OUT_W'((2 * num + den) / (2 * den));
            end
        end
        return t;
    endfunction

    localparam sq_tbl_t  SQ_TBL  = build_sq_tbl();
    localparam tnd_tbl_t TND_TBL = build_tnd_tbl();

    logic [3:0] sq1m, sq2m, trim, noisem;
    logic [6:0] dmcm;

    assign sq1m   = ch_enable[0] ? sq1      : 4'd0;
    assign sq2m   = ch_enable[1] ? sq2      : 4'd0;
    assign trim   = ch_enable[2] ? triangle : 4'd0;
    assign noisem = ch_enable[3] ? noise    : 4'd0;
    assign dmcm   = ch_enable[4] ? dmc      : 7'd0;

    logic             v1, v2, v3;
    logic [4:0]       sq_idx;
    logic [7:0]       tnd_idx;
    logic [OUT_W-1:0] sq_val, tnd_val, mix;
    logic [OUT_W:0]   pair_sum;

    assign pair_sum = {1'b0, sq_val} + {1'b0, tnd_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            sq_idx  <= '0;
            tnd_idx <= '0;
            sq_val  <= '0;
            tnd_val <= '0;
            mix     <= '0;
        end else begin
            v1 <= tick;
            v2 <= v1;
            v3 <= v2;
            if (tick) begin
                sq_idx  <= {1'b0, sq1m} + {1'b0, sq2m};
                tnd_idx <= {4'd0, trim} + {4'd0, trim} + {4'd0, trim}
                         + {3'd0, noisem, 1'b0} + {1'b0, dmcm};
            end
            if (v1) begin
                sq_val  <= SQ_TBL[sq_idx];
                tnd_val <= TND_TBL[tnd_idx];
            end
            if (v2) begin
                mix <= pair_sum[OUT_W] ? '1 : pair_sum[OUT_W-1:0];
            end
        end
    end

    logic [ACC_W-1:0] acc, acc_sum;
    logic [CNT_W-1:0] cnt;
    logic             window_done;
    logic [OUT_W-1:0] avg, atten, out_val;

    // With no decimation every mixed sample closes its own one-entry window.
    assign window_done = (DECIM_LOG2 == 0) || (cnt == '1);
    assign acc_sum     = acc + ACC_W'(mix);
    assign avg         = OUT_W'(acc_sum >> DECIM_LOG2);
    assign atten       = avg >> vol;
    assign out_val     = (SIGNED_OUT != 0) ? (atten - HALF) : atten;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            cnt          <= '0;
            sample_out   <= RESET_OUT;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (v3) begin
                if (!window_done) begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end else begin
                    acc          <= '0;
                    cnt          <= '0;
                    sample_out   <= out_val;
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_papu_mixer.sv
// Bench for papu_mixer: three builds (plain, signed, 4x decimation) share one
// stimulus stream and are checked every cycle against a real-arithmetic model.
module tb_papu_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tick;
    logic [3:0] sq1, sq2, triangle, noise;
    logic [6:0] dmc;
    logic [4:0] ch_enable;
    logic [1:0] vol;

    logic [15:0] so0, so1, so2;
    logic        sv0, sv1, sv2;

    papu_mixer #(.OUT_W(16), .DECIM_LOG2(0), .SIGNED_OUT(0)) u_plain (
        .clk(clk), .reset(reset), .tick(tick), .sq1(sq1), .sq2(sq2),
        .triangle(triangle), .noise(noise), .dmc(dmc), .ch_enable(ch_enable),
        .vol(vol), .sample_out(so0), .sample_valid(sv0)
    );

    papu_mixer #(.OUT_W(16), .DECIM_LOG2(0), .SIGNED_OUT(1)) u_signed (
        .clk(clk), .reset(reset), .tick(tick), .sq1(sq1), .sq2(sq2),
        .triangle(triangle), .noise(noise), .dmc(dmc), .ch_enable(ch_enable),
        .vol(vol), .sample_out(so1), .sample_valid(sv1)
    );

    papu_mixer #(.OUT_W(16), .DECIM_LOG2(2), .SIGNED_OUT(0)) u_decim (
        .clk(clk), .reset(reset), .tick(tick), .sq1(sq1), .sq2(sq2),
        .triangle(triangle), .noise(noise), .dmc(dmc), .ch_enable(ch_enable),
        .vol(vol), .sample_out(so2), .sample_valid(sv2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sv0_cnt = 0;
    bit model_ready = 1'b0;

    typedef struct {
        int inst;
        int due;
        int avg;
    } pend_t;

    pend_t exp_q[$];
    int    win_sum[3];
    int    win_cnt[3];
    int    exp_out[3];
    bit    exp_valid[3];

    function automatic int dl(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    function automatic bit sg(input int i);
        return (i == 1);
    endfunction

    function automatic int sq_ref(input int n);
        real r;
        if (n == 0) return 0;
        r = 95.52 / (8128.0 / n + 100.0) * 65535.0;
        return $rtoi(r + 0.5);
    endfunction

    function automatic int tnd_ref(input int n);
        real r;
        if (n == 0) return 0;
        r = 163.67 / (24329.0 / n + 100.0) * 65535.0;
        return $rtoi(r + 0.5);
    endfunction

    function automatic int mix_ref(input int a, input int b, input int t,
                                   input int n, input int d, input logic [4:0] en);
        int s;
        int m;
        s = (en[0] ? a : 0) + (en[1] ? b : 0);
        m = sq_ref(s) + tnd_ref(3 * (en[2] ? t : 0) + 2 * (en[3] ? n : 0) + (en[4] ? d : 0));
        return (m > 65535) ? 65535 : m;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        pend_t e;
        int    m;
        int    u;
        cyc++;
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
                win_sum[i]   = 0;
                win_cnt[i]   = 0;
                exp_valid[i] = 1'b0;
                exp_out[i]   = sg(i) ? 32768 : 0;
            end
            model_ready = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) exp_valid[i] = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                u = e.avg >> vol;
                exp_out[e.inst]   = sg(e.inst) ? ((u - 32768) & 32'hFFFF) : u;
                exp_valid[e.inst] = 1'b1;
            end
            if (tick) begin
                m = mix_ref(sq1, sq2, triangle, noise, dmc, ch_enable);
                for (int i = 0; i < 3; i++) begin
                    win_sum[i] += m;
                    win_cnt[i]++;
                    if (win_cnt[i] == (1 << dl(i))) begin
                        e.inst = i;
                        e.due  = cyc + 3;
                        e.avg  = win_sum[i] >> dl(i);
                        exp_q.push_back(e);
                        win_sum[i] = 0;
                        win_cnt[i] = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ready) begin
            check("valid_plain",  int'(sv0), int'(exp_valid[0]));
            check("valid_signed", int'(sv1), int'(exp_valid[1]));
            check("valid_decim",  int'(sv2), int'(exp_valid[2]));
            check("out_plain",    int'(so0), exp_out[0]);
            check("out_signed",   int'(so1), exp_out[1]);
            check("out_decim",    int'(so2), exp_out[2]);
            if (sv0) sv0_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_codes(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t,
                             input logic [3:0] n, input logic [6:0] d, input logic [4:0] en);
        sq1       = a;
        sq2       = b;
        triangle  = t;
        noise     = n;
        dmc       = d;
        ch_enable = en;
    endtask

    // Leaves the caller on the negedge right after the result edge (tick + 4).
    task automatic one_tick(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t,
                            input logic [3:0] n, input logic [6:0] d, input logic [4:0] en,
                            input logic [1:0] v);
        @(negedge clk);
        set_codes(a, b, t, n, d, en);
        vol  = v;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [3:0] pat [4];
    logic [3:0] vt_a [8];
    logic [3:0] vt_t [8];
    logic [6:0] vt_d [8];
    logic [4:0] vt_e [8];

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        set_codes(4'd0, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111);
        vol = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_out_plain",  int'(so0), 0);
        check("rst_out_signed", int'(so1), 16'h8000);
        check("rst_valid",      int'(sv0), 0);
        reset = 1'b0;

        check("model_sq1",    sq_ref(1),    761);
        check("model_sq30",   sq_ref(30),   16876);
        check("model_tnd202", tnd_ref(202), 48658);

        one_tick(4'd0, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111, 2'd0);
        check("zero_valid",  int'(sv0), 1);
        check("zero_out",    int'(so0), 0);
        check("zero_signed", int'(so1), 16'h8000);

        one_tick(4'd1, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111, 2'd0);
        check("sq1_out",    int'(so0), 761);
        check("sq1_signed", int'(so1), 16'h82F9);

        one_tick(4'd1, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11110, 2'd0);
        check("sq1_muted", int'(so0), 0);

        one_tick(4'd0, 4'd0, 4'd0, 4'd1, 7'd0, 5'b11111, 2'd0);
        check("noise1_out", int'(so0), 875);

        one_tick(4'd1, 4'd0, 4'd0, 4'd1, 7'd0, 5'b11111, 2'd0);
        check("sq1_noise1_out", int'(so0), 1636);

        one_tick(4'd1, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111, 2'd2);
        check("sq1_vol2_out", int'(so0), 190);
        vol = 2'd0;

        // Four-tick window on the decimating build: (0+0+761+761)/4.
        do_reset();
        pat[0] = 4'd0; pat[1] = 4'd0; pat[2] = 4'd1; pat[3] = 4'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_codes(pat[k], 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("decim_valid", int'(sv2), 1);
        check("decim_out",   int'(so2), 380);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_codes(4'd1, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("decim_restart_out", int'(so2), 761);

        // Back-to-back full-scale ticks: one output per tick, none dropped.
        repeat (2) @(negedge clk);
        sv0_cnt = 0;
        set_codes(4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 5'b11111);
        tick = 1'b1;
        repeat (20) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        check("cont_pulses", sv0_cnt, 20);
        check("cont_max_out", int'(so0), 65534);

        // Reset between ticks 2 and 3 of a window.
        do_reset();
        @(negedge clk);
        set_codes(4'd15, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111);
        tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_codes(4'd1, 4'd0, 4'd0, 4'd0, 7'd0, 5'b11111);
        tick = 1'b1;
        repeat (4) @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_valid", int'(sv2), 1);
        check("rst_mid_out",   int'(so2), 761);

        // Mixed codes with gaps; checked cycle by cycle against the model.
        vt_a[0] = 4'd3;  vt_t[0] = 4'd7;  vt_d[0] = 7'd64;  vt_e[0] = 5'b11111;
        vt_a[1] = 4'd15; vt_t[1] = 4'd0;  vt_d[1] = 7'd1;   vt_e[1] = 5'b10101;
        vt_a[2] = 4'd8;  vt_t[2] = 4'd15; vt_d[2] = 7'd127; vt_e[2] = 5'b01011;
        vt_a[3] = 4'd1;  vt_t[3] = 4'd2;  vt_d[3] = 7'd33;  vt_e[3] = 5'b11111;
        vt_a[4] = 4'd12; vt_t[4] = 4'd9;  vt_d[4] = 7'd100; vt_e[4] = 5'b00000;
        vt_a[5] = 4'd6;  vt_t[5] = 4'd11; vt_d[5] = 7'd7;   vt_e[5] = 5'b11100;
        vt_a[6] = 4'd10; vt_t[6] = 4'd4;  vt_d[6] = 7'd90;  vt_e[6] = 5'b11111;
        vt_a[7] = 4'd2;  vt_t[7] = 4'd13; vt_d[7] = 7'd55;  vt_e[7] = 5'b10011;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_codes(vt_a[k], 4'(15 - vt_a[k]), vt_t[k], 4'(vt_t[k] ^ 4'd5), vt_d[k], vt_e[k]);
            vol  = 2'(k);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/papu_mixer.md
Name: papu_mixer

Overview:
Parametrised nonlinear APU channel mixer for the PAPU audio path.
- Takes the five channel DAC codes (2x square, triangle, noise, DMC) on a tick strobe and applies the standard NES pulse/TND nonlinear mix through elaboration-computed lookup tables.
- Adds per-channel mute, power-of-two box-filter decimation, attenuation and an optional signed output format.
- Sits between the channel generators and the codec/audio-out interface.

Parameters:
OUT_W, 16, output/table width in bits; legal 12..16.
DECIM_LOG2, 0, log2 of ticks averaged per output sample; legal 0..8.
SIGNED_OUT, 0, 0 = offset-binary (unsigned) output; 1 = two's complement output.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tick  in  1  channel-sample strobe; inputs captured when high
sq1  in  4  square 1 code
sq2  in  4  square 2 code
tri  in  4  triangle code
noise  in  4  noise code
dmc  in  7  DMC code
ch_enable  in  5  per-channel enable [0]=sq1 [1]=sq2 [2]=tri [3]=noise [4]=dmc; 0 forces that code to 0
vol  in  2  attenuation; output right-shifted by vol
sample_out  out  OUT_W  mixed sample, held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. At reset: sample_out = 0 (unsigned mode) or -2^(OUT_W-1) (signed mode); sample_valid = 0; pipeline valids, accumulator and tick counter = 0.
- Reset mid-operation: discards any in-flight ticks and any partial decimation window.
- Tables, built at elaboration by a constant function:
  - Square table, 31 entries: sq_tbl[n] = round(95.52/(8128/n+100) * (2^OUT_W-1)); sq_tbl[0] = 0.
  - TND table, 203 entries: tnd_tbl[n] = round(163.67/(24329/n+100) * (2^OUT_W-1)); tnd_tbl[0] = 0.
- Stage 1, on tick: register masked codes plus valid bit v1.
  - sq_idx = sq1m + sq2m (5b, max 30).
  - tnd_idx = 3*trim + 2*noisem + dmcm (8b, max 202).
- Stage 2: register sq_tbl[sq_idx] and tnd_tbl[tnd_idx]; v2 <= v1.
- Stage 3: mix = sum of both lookups, saturated to 2^OUT_W-1; v3 <= v2. Max table sum is below full scale; the saturation is a guard only.
- Accumulator and decimation, applied when v3 = 1:
  - acc is OUT_W+DECIM_LOG2 bits wide and cnt is DECIM_LOG2 bits wide.
  - If cnt != 2^DECIM_LOG2-1: acc += mix and cnt += 1.
  - Else (window complete): avg = (acc+mix) >> DECIM_LOG2; acc <= 0; cnt <= 0; u = avg >> vol.
  - Then sample_out <= SIGNED_OUT ? u - 2^(OUT_W-1) : u, with sample_valid = 1 for that one clock.
- With DECIM_LOG2 = 0, every tick produces an output.
- Latency: a tick at cycle t gives sample_valid at cycle t+4 for the tick that completes a window.
- Throughput: tick may assert every cycle, including back-to-back, with no loss.
- Timing of other inputs:
  - ch_enable and the channel codes are sampled together on the tick cycle only.
  - vol is sampled at the window-complete cycle.
- Boundary conditions:
  - tick low: the pipeline holds bubbles and sample_out holds its value.
  - sample_valid is never high for two consecutive cycles unless DECIM_LOG2 = 0 and tick is continuous.

Test Plan:
- Reset, OUT_W=16, DECIM_LOG2=0, unsigned; all codes 0, ch_enable=5'b11111, one tick -> sample_valid exactly 4 cycles later, sample_out=0.
- sq1=1, others 0, tick -> sample_out=761; repeat with ch_enable[0]=0 -> 0; noise=1 only -> 875; sq1=1 plus noise=1 -> 1636.
- sq1=1, vol=2 -> 190; SIGNED_OUT=1 build, all zero -> 16'h8000; sq1=1 -> 16'h82F9.
- DECIM_LOG2=2: ticks on 4 consecutive cycles with sq1 = 0,0,1,1 -> one sample_valid, sample_out=380; acc restarts at next window.
- Continuous ticks at DECIM_LOG2=0 with sq1 = 15, sq2 = 15, tri = 15, noise = 15, dmc = 127 -> sample_out equals sq_tbl[30]+tnd_tbl[202] (≤ 65535) every cycle, no drops.
- Assert reset for one cycle between ticks 2 and 3 of a DECIM_LOG2=2 window -> no sample_valid for the old window; next output averages only the 4 post-reset ticks.
